window_fetch_ctrl: RTL and testbench
====================================

# window_fetch_ctrl

Sequencer for the 3x3 median-filter window fetch from the single-port image block RAM (IMG_W x IMG_H, 8-bit pixels). It scans every interior pixel in raster order and issues the nine neighbourhood read addresses, compensating for the fixed BRAM read latency. It packs each window into a 72-bit word and hands it to the filter datapath over a valid/ready handshake with backpressure. Frame processing is bracketed by start/busy/done.

## Interface
- IMG_W, 100, image width in pixels (>= 3)
- IMG_H, 100, image height in pixels (>= 3)
- ADDR_W, 14, BRAM address width
- PIX_W, 8, pixel width
- RD_LAT, 1, BRAM read latency in cycles (1..2)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last window handshake
- bram_en  out  1  read strobe to image BRAM
- bram_addr  out  ADDR_W  read address (registered)
- bram_dout  in  PIX_W  BRAM read data, valid RD_LAT cycles after address
- win_data  out  9*PIX_W  window {p00,p01,p02,p10,p11,p12,p20,p21,p22}; p00 in [71:64], row-major, p11 is the centre pixel
- win_valid  out  1  window available
- win_ready  in  1  consumer accepts window
- win_row, win_col  out  ADDR_W  centre coordinates of the presented window

## Operation
- States: IDLE -> FETCH -> WAIT -> HOLD -> (FETCH | DONE) -> IDLE.
- IDLE: start=1 clears row=1, col=1, and moves to FETCH. start is ignored in every other state.
- FETCH: one read per cycle; bram_en=1; address = r*IMG_W + c, with r in row-1..row+1 and c in col-1..col+1, issued in row-major order.
- Address arithmetic is at least ADDR_W bits wide, so there is no wrap for IMG_W*IMG_H <= 2^ADDR_W.
- WAIT: RD_LAT cycles with bram_en=0, draining outstanding reads.
- bram_dout is captured into the slot of the address issued RD_LAT cycles earlier.
- HOLD: win_valid=1. win_data, win_row and win_col stay stable until win_valid && win_ready.
- On handshake, col advances by 1. At col == IMG_W-2 the next window is col=1, row+1.
- Handshake of window (IMG_H-2, IMG_W-2) goes to DONE instead of advancing.
- DONE: done=1 for one cycle, busy=0 on the next cycle, return to IDLE.
- Window count per frame is (IMG_W-2)*(IMG_H-2), which is 9604 at the defaults.

## Timing
- Reset values: busy, done, bram_en, win_valid = 0; bram_addr, win_data, win_row, win_col = 0; state IDLE.
- Reset mid-frame aborts the fetch immediately. No done pulse is produced and no further BRAM reads are issued.
- Cycle 0 is the first FETCH cycle, which is the cycle after start is sampled.
- Addresses are issued in cycles 0..8. win_valid asserts in cycle 9+RD_LAT.
- With win_ready held high, the handshake happens in that same cycle and the next FETCH starts the cycle after.
- Window period without backpressure: 10+RD_LAT cycles.
- win_ready low stalls in HOLD indefinitely, with no BRAM reads during the stall.

## Configuration
- WINDOW_REUSE_EN defined: on a column advance within a row, the block shifts the columns left (p00<=p01, p01<=p02, and likewise for rows 1 and 2). It then fetches only the three new right-column pixels, giving a period of 4+RD_LAT cycles. The first window of every row still does the full 9-read fetch.
- WINDOW_REUSE_EN undefined: every window does the full 9-read fetch.
- The window sequence, data and done timing rules are otherwise identical in both builds.

## Structure
- Shared package img_pkg holds:
  - IMG_W, IMG_H, PIX_W and ADDR_W defaults
  - WIN_PIX=9
  - the state enum (IDLE, FETCH, WAIT, HOLD, DONE)
  - the window slot-index constants
- One sub-module, win_addr_gen:
  - holds the row/col counters and the per-slot address generation, using incremental adds, not multipliers
  - outputs the next address and the last-window flag

## Test plan
(BRAM model: dout = addr[7:0], RD_LAT=1.)
- Reset, start, win_ready=1 -> first window addresses 0,1,2,100,101,102,200,201,202. win_data=0x000102646566C8C9CA at cycle 10, win_row=1, win_col=1.
- Second window, reuse undefined -> nine reads 1..203. With WINDOW_REUSE_EN -> only addresses 3,103,203 are read. In both builds win_data=0x010203656667C9CACB; with reuse, win_valid comes 5 cycles after the first handshake.
- win_ready=0 for 6 cycles in HOLD -> win_data, win_row and win_col stable, bram_en=0 throughout, single handshake on release.
- Row wrap: the handshake of (1,98) is followed by window (2,1) with first address 100 -> win_data=0x646566C8C9CA2C2D2E.
- Full frame with win_ready=1 -> exactly 9604 handshakes, then one done pulse. Last handshake at cycle 105643 without reuse, or 48607 with WINDOW_REUSE_EN. Then busy=0.
- rst asserted in cycle 5 of FETCH -> all outputs 0 asynchronously, no done pulse. A new start then restarts at window (1,1).

Source files
------------

// File: rtl/img_pkg.sv
// Shared types and constants for the 3x3 window fetch path.
// Default image geometry, window size, FSM states and window slot indices.
package img_pkg;

    localparam int unsigned IMG_W_DEF  = 100;
    localparam int unsigned IMG_H_DEF  = 100;
    localparam int unsigned PIX_W_DEF  = 8;
    localparam int unsigned ADDR_W_DEF = 14;
    localparam int unsigned WIN_PIX    = 9;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        HOLD,
        DONE
    } state_t;

    typedef logic [3:0] slot_t;

    // Row-major slot order: slot 0 is p00 (top-left), slot 8 is p22.
    localparam slot_t SLOT_P00 = 4'd0;
    localparam slot_t SLOT_P01 = 4'd1;
    localparam slot_t SLOT_P02 = 4'd2;
    localparam slot_t SLOT_P10 = 4'd3;
    localparam slot_t SLOT_P11 = 4'd4;
    localparam slot_t SLOT_P12 = 4'd5;
    localparam slot_t SLOT_P20 = 4'd6;
    localparam slot_t SLOT_P21 = 4'd7;
    localparam slot_t SLOT_P22 = 4'd8;

endpackage

// File: rtl/win_addr_gen.sv
// Window centre counters and per-slot read address walk (adds only, no multiply).
// WINDOW_REUSE_EN: column advances within a row fetch only the new right column.
module win_addr_gen
    import img_pkg::*;
#(
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned IMG_H  = IMG_H_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_init,
    input  logic              i_step,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_addr,
    output slot_t             o_slot,
    output logic              o_last_slot,
    output logic              o_row_end,
    output logic              o_last_win,
    output logic [ADDR_W-1:0] o_row,
    output logic [ADDR_W-1:0] o_col
);

    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ROW_SKIP   = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] LAST_COL   = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] LAST_ROW   = ADDR_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] THREE      = ADDR_W'(3);

    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_cur;
    slot_t             r_slot;
    logic [1:0]        r_scol;
    logic              r_partial;

    // r_base tracks the top-left address (row-1)*IMG_W + (col-1) of the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row     <= '0;
            r_col     <= '0;
            r_base    <= '0;
            r_cur     <= '0;
            r_slot    <= SLOT_P00;
            r_scol    <= '0;
            r_partial <= 1'b0;
        end else if (i_init) begin
            r_row     <= ONE;
            r_col     <= ONE;
            r_base    <= '0;
            r_cur     <= '0;
            r_slot    <= SLOT_P00;
            r_scol    <= '0;
            r_partial <= 1'b0;
        end else if (i_advance) begin
            if (o_row_end) begin
                r_row     <= r_row + ONE;
                r_col     <= ONE;
                r_base    <= r_base + THREE;
                r_cur     <= r_base + THREE;
                r_slot    <= SLOT_P00;
                r_scol    <= '0;
                r_partial <= 1'b0;
            end else begin
                r_col  <= r_col + ONE;
                r_base <= r_base + ONE;
`ifdef WINDOW_REUSE_EN
                r_cur     <= r_base + THREE;
                r_slot    <= SLOT_P02;
                r_scol    <= 2'd2;
                r_partial <= 1'b1;
`else
                r_cur     <= r_base + ONE;
                r_slot    <= SLOT_P00;
                r_scol    <= '0;
                r_partial <= 1'b0;
`endif
            end
        end else if (i_step) begin
            if (r_partial) begin
                r_cur  <= r_cur + ROW_STRIDE;
                r_slot <= r_slot + 4'd3;
            end else if (r_scol == 2'd2) begin
                r_cur  <= r_cur + ROW_SKIP;
                r_slot <= r_slot + 4'd1;
                r_scol <= '0;
            end else begin
                r_cur  <= r_cur + ONE;
                r_slot <= r_slot + 4'd1;
                r_scol <= r_scol + 2'd1;
            end
        end
    end

    assign o_addr      = r_cur;
    assign o_slot      = r_slot;
    assign o_last_slot = (r_slot == SLOT_P22);
    assign o_row_end   = (r_col == LAST_COL);
    assign o_last_win  = (r_col == LAST_COL) && (r_row == LAST_ROW);
    assign o_row       = r_row;
    assign o_col       = r_col;

endmodule

// File: rtl/window_fetch_ctrl.sv
// 3x3 median-filter window fetch sequencer: BRAM reads, latency-aligned capture, valid/ready out.
// WINDOW_REUSE_EN: shift columns left on in-row advance and fetch only three new pixels.
module window_fetch_ctrl
    import img_pkg::*;
#(
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned IMG_H  = IMG_H_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned PIX_W  = PIX_W_DEF,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     bram_en,
    output logic [ADDR_W-1:0]        bram_addr,
    input  logic [PIX_W-1:0]         bram_dout,
    output logic [WIN_PIX*PIX_W-1:0] win_data,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [ADDR_W-1:0]        win_row,
    output logic [ADDR_W-1:0]        win_col
);

    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_bram_en;
    logic              r_win_valid;
    logic [1:0]        r_wait_cnt;
    logic [PIX_W-1:0]  r_win [WIN_PIX];
    logic              r_pv  [1:RD_LAT];
    slot_t             r_ps  [1:RD_LAT];

    logic              w_init;
    logic              w_step;
    logic              w_hs;
    logic              w_adv;
    logic              w_last_slot;
    logic              w_row_end;
    logic              w_last_win;
    slot_t             w_slot;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_col;

    assign w_init = (r_state == IDLE) && start;
    assign w_step = (r_state == FETCH) && !w_last_slot;
    assign w_hs   = (r_state == HOLD) && win_ready;
    assign w_adv  = w_hs && !w_last_win;

    win_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .i_init      (w_init),
        .i_step      (w_step),
        .i_advance   (w_adv),
        .o_addr      (w_addr),
        .o_slot      (w_slot),
        .o_last_slot (w_last_slot),
        .o_row_end   (w_row_end),
        .o_last_win  (w_last_win),
        .o_row       (w_row),
        .o_col       (w_col)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bram_en   <= 1'b0;
            r_win_valid <= 1'b0;
            r_wait_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= FETCH;
                        r_busy    <= 1'b1;
                        r_bram_en <= 1'b1;
                    end
                end
                FETCH: begin
                    if (w_last_slot) begin
                        r_state    <= WAIT;
                        r_bram_en  <= 1'b0;
                        r_wait_cnt <= WAIT_LAST;
                    end
                end
                WAIT: begin
                    if (r_wait_cnt == 2'd0) begin
                        r_state     <= HOLD;
                        r_win_valid <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                HOLD: begin
                    if (win_ready) begin
                        r_win_valid <= 1'b0;
                        if (w_last_win) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= FETCH;
                            r_bram_en <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Slot tag follows each read so data lands in the slot of the address RD_LAT cycles back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 1; i <= RD_LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_ps[i] <= SLOT_P00;
            end
        end else begin
            r_pv[1] <= r_bram_en;
            r_ps[1] <= w_slot;
            for (int unsigned i = 2; i <= RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_ps[i] <= r_ps[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < WIN_PIX; i++) begin
                r_win[i] <= '0;
            end
        end else begin
`ifdef WINDOW_REUSE_EN
            if (w_adv && !w_row_end) begin
                r_win[SLOT_P00] <= r_win[SLOT_P01];
                r_win[SLOT_P01] <= r_win[SLOT_P02];
                r_win[SLOT_P10] <= r_win[SLOT_P11];
                r_win[SLOT_P11] <= r_win[SLOT_P12];
                r_win[SLOT_P20] <= r_win[SLOT_P21];
                r_win[SLOT_P21] <= r_win[SLOT_P22];
            end
`endif
            if (r_pv[RD_LAT]) begin
                r_win[r_ps[RD_LAT]] <= bram_dout;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < WIN_PIX; i++) begin
            win_data[(WIN_PIX-1-i)*PIX_W +: PIX_W] = r_win[i];
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign bram_en   = r_bram_en;
    assign bram_addr = w_addr;
    assign win_valid = r_win_valid;
    assign win_row   = w_row;
    assign win_col   = w_col;

endmodule

// File: tb/tb_window_fetch_ctrl.sv
// Directed bench for window_fetch_ctrl: 100x100 instance for sequencing, 5x4 instance for a full frame.
module tb_window_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, bram_en, win_valid, win_ready;
    logic [13:0] bram_addr, win_row, win_col;
    logic [7:0]  bram_dout = '0;
    logic [71:0] win_data;

    logic        s_start;
    logic        s_busy, s_done, s_bram_en, s_valid, s_ready;
    logic [13:0] s_bram_addr, s_row, s_col;
    logic [7:0]  s_bram_dout = '0;
    logic [71:0] s_data;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [13:0] a_first [9] = '{14'd0, 14'd1, 14'd2, 14'd100, 14'd101, 14'd102, 14'd200, 14'd201, 14'd202};
`ifdef WINDOW_REUSE_EN
    logic [13:0] a_second [3] = '{14'd3, 14'd103, 14'd203};
    localparam int unsigned N_SECOND    = 3;
    localparam int unsigned SMALL_LAST  = 41;
    localparam logic [13:0] THIRD_ADDR  = 14'd4;
`else
    logic [13:0] a_second [9] = '{14'd1, 14'd2, 14'd3, 14'd101, 14'd102, 14'd103, 14'd201, 14'd202, 14'd203};
    localparam int unsigned N_SECOND    = 9;
    localparam int unsigned SMALL_LAST  = 65;
    localparam logic [13:0] THIRD_ADDR  = 14'd2;
`endif

    localparam logic [71:0] WIN_FIRST  = 72'h000102646566C8C9CA;
    localparam logic [71:0] WIN_SECOND = 72'h010203656667C9CACB;
    localparam logic [71:0] WIN_WRAP   = 72'h646566C8C9CA2C2D2E;
    localparam logic [71:0] WIN_SMALL  = 72'h0708090C0D0E111213;

    always #5 clk = ~clk;

    always @(posedge clk) if (bram_en) bram_dout <= bram_addr[7:0];
    always @(posedge clk) if (s_bram_en) s_bram_dout <= s_bram_addr[7:0];

    window_fetch_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .bram_en   (bram_en),
        .bram_addr (bram_addr),
        .bram_dout (bram_dout),
        .win_data  (win_data),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_row   (win_row),
        .win_col   (win_col)
    );

    window_fetch_ctrl #(
        .IMG_W (5),
        .IMG_H (4)
    ) u_small (
        .clk       (clk),
        .rst       (rst),
        .start     (s_start),
        .busy      (s_busy),
        .done      (s_done),
        .bram_en   (s_bram_en),
        .bram_addr (s_bram_addr),
        .bram_dout (s_bram_dout),
        .win_data  (s_data),
        .win_valid (s_valid),
        .win_ready (s_ready),
        .win_row   (s_row),
        .win_col   (s_col)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic        found;
    logic        stable;
    logic        any_act;
    int unsigned hs_cnt, dn_cnt, last_hs, done_cyc;
    logic        busy_at_done, busy_after;
    logic [71:0] last_data;

    initial begin
        rst = 1'b1; start = 1'b0; win_ready = 1'b0; s_start = 1'b0; s_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy",  72'(busy), 72'(0));
        chk("rst_done",  72'(done), 72'(0));
        chk("rst_en",    72'(bram_en), 72'(0));
        chk("rst_valid", 72'(win_valid), 72'(0));
        chk("rst_addr",  72'(bram_addr), 72'(0));
        chk("rst_data",  win_data, 72'(0));
        chk("rst_row",   72'(win_row), 72'(0));
        chk("rst_col",   72'(win_col), 72'(0));

        rst = 1'b0; win_ready = 1'b1;
        @(negedge clk);
        start = 1'b1; tick(); start = 1'b0;
        chk("busy_c0", 72'(busy), 72'(1));
        for (int unsigned k = 0; k < 9; k++) begin
            chk("w1_en", 72'(bram_en), 72'(1));
            chk("w1_addr", 72'(bram_addr), 72'(a_first[k]));
            tick();
        end
        chk("w1_en_c9", 72'(bram_en), 72'(0));
        chk("w1_valid_c9", 72'(win_valid), 72'(0));
        tick();
        chk("w1_valid_c10", 72'(win_valid), 72'(1));
        chk("w1_data", win_data, WIN_FIRST);
        chk("w1_row", 72'(win_row), 72'(1));
        chk("w1_col", 72'(win_col), 72'(1));
        tick();
        win_ready = 1'b0;

        for (int unsigned k = 0; k < N_SECOND; k++) begin
            chk("w2_en", 72'(bram_en), 72'(1));
            chk("w2_addr", 72'(bram_addr), 72'(a_second[k]));
            tick();
        end
        chk("w2_wait_en", 72'(bram_en), 72'(0));
        chk("w2_wait_valid", 72'(win_valid), 72'(0));
        tick();
        chk("w2_valid", 72'(win_valid), 72'(1));
        chk("w2_data", win_data, WIN_SECOND);
        chk("w2_row", 72'(win_row), 72'(1));
        chk("w2_col", 72'(win_col), 72'(2));

        stable = 1'b1;
        for (int unsigned k = 0; k < 6; k++) begin
            stable &= win_valid && !bram_en && (win_data === WIN_SECOND) && (win_row == 14'd1) && (win_col == 14'd2);
            tick();
        end
        chk("stall_stable", 72'(stable), 72'(1));
        win_ready = 1'b1;
        chk("stall_valid_release", 72'(win_valid), 72'(1));
        tick();
        chk("post_hs_valid", 72'(win_valid), 72'(0));
        chk("post_hs_col", 72'(win_col), 72'(3));
        chk("post_hs_en", 72'(bram_en), 72'(1));
        chk("post_hs_addr", 72'(bram_addr), 72'(THIRD_ADDR));

        found = 1'b0;
        for (int unsigned i = 0; i < 2000; i++) begin
            if (win_valid && win_row == 14'd1 && win_col == 14'd98) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("wrap_reach_98", 72'(found), 72'(1));
        tick();
        chk("wrap_en", 72'(bram_en), 72'(1));
        chk("wrap_addr", 72'(bram_addr), 72'(100));
        chk("wrap_row", 72'(win_row), 72'(2));
        chk("wrap_col", 72'(win_col), 72'(1));
        found = 1'b0;
        for (int unsigned i = 0; i < 30; i++) begin
            if (win_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("wrap_valid", 72'(found), 72'(1));
        chk("wrap_data", win_data, WIN_WRAP);

        rst = 1'b1;
        #1;
        chk("hold_rst_valid", 72'(win_valid), 72'(0));
        chk("hold_rst_busy", 72'(busy), 72'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        chk("c5_en", 72'(bram_en), 72'(1));
        chk("c5_addr", 72'(bram_addr), 72'(102));
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 72'(busy), 72'(0));
        chk("arst_en", 72'(bram_en), 72'(0));
        chk("arst_addr", 72'(bram_addr), 72'(0));
        chk("arst_data", win_data, 72'(0));
        chk("arst_rowcol", 72'({win_row, win_col}), 72'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        any_act = 1'b0;
        for (int unsigned i = 0; i < 15; i++) begin
            any_act |= done | busy | bram_en | win_valid;
            tick();
        end
        chk("abort_quiet", 72'(any_act), 72'(0));
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_addr", 72'(bram_addr), 72'(0));
        chk("restart_en", 72'(bram_en), 72'(1));
        chk("restart_row", 72'(win_row), 72'(1));
        chk("restart_col", 72'(win_col), 72'(1));
        found = 1'b0;
        for (int unsigned i = 0; i < 30; i++) begin
            if (win_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("restart_valid", 72'(found), 72'(1));
        chk("restart_data", win_data, WIN_FIRST);

        hs_cnt = 0; dn_cnt = 0; last_hs = 0; done_cyc = 0;
        busy_at_done = 1'b0; busy_after = 1'b1; last_data = '0;
        s_start = 1'b1; tick(); s_start = 1'b0;
        for (int unsigned cyc = 0; cyc < 120; cyc++) begin
            if (s_valid && s_ready) begin
                hs_cnt++;
                last_hs   = cyc;
                last_data = s_data;
            end
            if (dn_cnt != 0 && cyc == done_cyc + 1) busy_after = s_busy;
            if (s_done) begin
                dn_cnt++;
                done_cyc     = cyc;
                busy_at_done = s_busy;
            end
            tick();
        end
        chk("frame_handshakes", 72'(hs_cnt), 72'(6));
        chk("frame_done_pulses", 72'(dn_cnt), 72'(1));
        chk("frame_last_hs_cyc", 72'(last_hs), 72'(SMALL_LAST));
        chk("frame_done_cyc", 72'(done_cyc), 72'(SMALL_LAST + 1));
        chk("frame_busy_at_done", 72'(busy_at_done), 72'(1));
        chk("frame_busy_after", 72'(busy_after), 72'(0));
        chk("frame_last_data", last_data, WIN_SMALL);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
